// File: rtl/xrv_lsu.sv
// Load/store unit: one outstanding load or store on a simple req/gnt/rvalid
// data bus. Misaligned accesses complete immediately with ls_misalign and
// never reach the bus. A flush cancels an ungranted request, or lets a
// granted one drain on the bus without reporting completion.
//
// state | meaning
// IDLE  | waiting for is_ls; the only state in which a start is accepted
// REQ   | dbus_req high, bus fields held stable until dbus_gnt
// RESP  | granted, waiting for dbus_rvalid
// ERR   | misaligned access, one-cycle ls_done/ls_misalign pulse
module xrv_lsu (
    input  logic        clk,
    input  logic        rstb,
    input  logic        is_ls,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic        ls_unsigned,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic        flush,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        ls_misalign,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic [1:0]  state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        pend_flush;
    logic        done_q;

    logic        start;
    logic        misaligned;
    logic        resp_done;
    logic        err_pulse;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    assign start      = (state == S_IDLE) && is_ls && !flush;
    assign misaligned = ((ls_size == 2'b01) && ls_addr[0]) ||
                        (ls_size[1] && (ls_addr[1:0] != 2'b00));

    // a response arriving together with a flush is drained but not reported
    assign resp_done  = (state == S_RESP) && dbus_rvalid && !flush && !pend_flush;
    assign err_pulse  = (state == S_ERR) && !flush;

    assign ls_done     = done_q | err_pulse;
    assign ls_misalign = err_pulse;

    assign dbus_req  = (state == S_REQ);
    assign dbus_we   = r_we;
    assign dbus_addr = {r_addr[31:2], 2'b00};

    // byte enables and lane-replicated write data from the captured request
    always_comb begin
        dbus_be    = 4'b1111;
        dbus_wdata = r_wdata;
        case (r_size)
            2'b00: begin
                dbus_be    = 4'b0001 << r_addr[1:0];
                dbus_wdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                dbus_be    = 4'b0011 << {r_addr[1], 1'b0};
                dbus_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                dbus_be    = 4'b1111;
                dbus_wdata = r_wdata;
            end
        endcase
    end

    // align the response to bit 0, then sign- or zero-extend to 32 bits
    always_comb begin
        shifted  = dbus_rdata >> {r_addr[1:0], 3'b000};
        load_ext = shifted;
        case (r_size)
            2'b00:   load_ext = {{24{shifted[7] & ~r_unsigned}}, shifted[7:0]};
            2'b01:   load_ext = {{16{shifted[15] & ~r_unsigned}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // control FSM
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) state <= misaligned ? S_ERR : S_REQ;
                S_REQ: begin
                    if (flush)         state <= S_IDLE;
                    else if (dbus_gnt) state <= S_RESP;
                end
                S_RESP: if (dbus_rvalid) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // capture the request on an accepted start; held for the whole transaction
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
        end else if (start) begin
            r_we       <= ls_we;
            r_size     <= ls_size;
            r_unsigned <= ls_unsigned;
            r_addr     <= ls_addr;
            r_wdata    <= ls_wdata;
        end
    end

    // remember a flush seen while waiting for the response
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pend_flush <= 1'b0;
        end else if (state == S_RESP && !dbus_rvalid) begin
            pend_flush <= pend_flush | flush;
        end else begin
            pend_flush <= 1'b0;
        end
    end

    // completion pulse and load result, one cycle after the response
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            done_q   <= 1'b0;
            ls_rdata <= 32'h0;
        end else begin
            done_q <= resp_done;
            if (resp_done && !r_we) ls_rdata <= load_ext;
        end
    end

endmodule

// File: tb/tb_xrv_lsu.sv
// Bench for xrv_lsu: directed scenarios plus randomized transactions
// checked against a byte-level reference model of the access rules.
module tb_xrv_lsu;

    logic        clk;
    logic        rstb;
    logic        is_ls;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic        ls_unsigned;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        flush;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        ls_misalign;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_rdata = 32'h0;

    xrv_lsu dut (
        .clk(clk), .rstb(rstb), .is_ls(is_ls), .ls_we(ls_we), .ls_size(ls_size),
        .ls_unsigned(ls_unsigned), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .flush(flush), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .ls_misalign(ls_misalign), .dbus_req(dbus_req), .dbus_we(dbus_we),
        .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
        .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, exp finished");
        $fatal(1, "timeout");
    end

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    // pick the addressed bytes out of the bus word, then extend
    function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [1:0] sz, input logic u);
        int n;
        int off;
        logic [31:0] v;
        n = nbytes(sz);
        off = int'(a[1:0]);
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
        if (!u && v[8*n-1]) for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        return v;
    endfunction

    task automatic idle_inputs();
        is_ls = 1'b0; flush = 1'b0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    endtask

    task automatic noise_fields(input bit noise);
        if (noise) begin
            is_ls = 1'($urandom); ls_we = 1'($urandom); ls_size = 2'($urandom);
            ls_unsigned = 1'($urandom); ls_addr = $urandom; ls_wdata = $urandom;
        end else begin
            is_ls = 1'b0;
        end
    endtask

    // One full transaction. fl_mode: 0 none, 1 flush in REQ cycle fl_at,
    // 2 flush in RESP cycle fl_at, 3 flush during the ERR cycle.
    task automatic do_txn(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                          input int fl_mode, input int fl_at, input bit noise);
        int n;
        bit mis;
        bit fl_pend;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] eaddr;
        n = nbytes(size);
        mis = (int'(addr[1:0]) % n) != 0;
        eaddr = addr & 32'hFFFF_FFFC;
        ebe = 4'b0000;
        for (int i = 0; i < n; i++) if (int'(addr[1:0]) + i < 4) ebe[int'(addr[1:0]) + i] = 1'b1;
        for (int k = 0; k < 4; k++) ewd[8*k +: 8] = wdata[8*(k % n) +: 8];

        @(negedge clk);
        idle_inputs();
        is_ls = 1'b1; ls_we = we; ls_size = size; ls_unsigned = uns;
        ls_addr = addr; ls_wdata = wdata;
        #1;
        checks++;
        if (dbus_req !== 1'b0) begin errors++; $display("FAIL start_req: got %b exp 0", dbus_req); end

        if (mis) begin
            @(negedge clk);
            noise_fields(noise);
            flush = (fl_mode == 3);
            #1;
            checks++;
            if (dbus_req !== 1'b0) begin errors++; $display("FAIL err_req: got %b exp 0", dbus_req); end
            checks++;
            if (ls_done !== !flush) begin errors++; $display("FAIL err_done: got %b exp %b", ls_done, !flush); end
            checks++;
            if (ls_misalign !== !flush) begin errors++; $display("FAIL err_misalign: got %b exp %b", ls_misalign, !flush); end
            checks++;
            if (ls_rdata !== model_rdata) begin errors++; $display("FAIL err_rdata: got %h exp %h", ls_rdata, model_rdata); end
            @(negedge clk);
            idle_inputs();
            #1;
            checks++;
            if (ls_done !== 1'b0 || dbus_req !== 1'b0) begin
                errors++; $display("FAIL err_after: got done=%b req=%b exp 0 0", ls_done, dbus_req);
            end
            return;
        end

        for (int k = 0; k <= gnt_dly; k++) begin
            @(negedge clk);
            idle_inputs();
            noise_fields(noise);
            dbus_gnt = (k == gnt_dly);
            dbus_rvalid = noise ? 1'($urandom) : 1'b0;
            flush = (fl_mode == 1 && k == fl_at);
            #1;
            checks++;
            if (dbus_req !== 1'b1) begin errors++; $display("FAIL req_held: got %b exp 1 (cycle %0d)", dbus_req, k); end
            checks++;
            if (dbus_we !== we || dbus_addr !== eaddr || dbus_be !== ebe) begin
                errors++;
                $display("FAIL req_fields: got we=%b addr=%h be=%b exp we=%b addr=%h be=%b",
                         dbus_we, dbus_addr, dbus_be, we, eaddr, ebe);
            end
            checks++;
            if (dbus_wdata !== ewd) begin errors++; $display("FAIL req_wdata: got %h exp %h", dbus_wdata, ewd); end
            checks++;
            if (ls_done !== 1'b0) begin errors++; $display("FAIL req_done: got %b exp 0", ls_done); end
            if (flush) begin
                @(negedge clk);
                idle_inputs();
                #1;
                checks++;
                if (dbus_req !== 1'b0 || ls_done !== 1'b0) begin
                    errors++; $display("FAIL flush_cancel: got req=%b done=%b exp 0 0", dbus_req, ls_done);
                end
                @(negedge clk);
                #1;
                checks++;
                if (ls_done !== 1'b0) begin errors++; $display("FAIL flush_cancel_late: got %b exp 0", ls_done); end
                return;
            end
        end

        fl_pend = 1'b0;
        for (int j = 0; j <= rv_dly; j++) begin
            @(negedge clk);
            idle_inputs();
            noise_fields(noise);
            dbus_gnt = noise ? 1'($urandom) : 1'b0;
            dbus_rvalid = (j == rv_dly);
            dbus_rdata = (j == rv_dly) ? rdata : $urandom;
            flush = (fl_mode == 2 && j == fl_at);
            if (flush) fl_pend = 1'b1;
            #1;
            checks++;
            if (dbus_req !== 1'b0 || ls_done !== 1'b0) begin
                errors++; $display("FAIL resp_wait: got req=%b done=%b exp 0 0", dbus_req, ls_done);
            end
        end
        if (!fl_pend && !we) model_rdata = exp_load(rdata, addr, size, uns);

        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (ls_done !== !fl_pend) begin errors++; $display("FAIL done_pulse: got %b exp %b", ls_done, !fl_pend); end
        checks++;
        if (ls_misalign !== 1'b0) begin errors++; $display("FAIL done_misalign: got %b exp 0", ls_misalign); end
        checks++;
        if (ls_rdata !== model_rdata) begin errors++; $display("FAIL load_data: got %h exp %h", ls_rdata, model_rdata); end
        @(negedge clk);
        #1;
        checks++;
        if (ls_done !== 1'b0) begin errors++; $display("FAIL done_single: got %b exp 0", ls_done); end
    endtask

    task automatic test_reset();
        idle_inputs();
        ls_we = 1'b0; ls_size = 2'b00; ls_unsigned = 1'b0; ls_addr = 32'h0;
        ls_wdata = 32'h0; dbus_rdata = 32'h0;
        rstb = 1'b0;
        #3;
        checks++;
        if (dbus_req !== 1'b0 || ls_done !== 1'b0 || ls_misalign !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: got req=%b done=%b mis=%b exp 0 0 0", dbus_req, ls_done, ls_misalign);
        end
        checks++;
        if (ls_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", ls_rdata); end
        @(negedge clk);
        rstb = 1'b1;
        model_rdata = 32'h0;
    endtask

    task automatic test_directed();
        // signed byte from the top lane
        do_txn(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0, 0, 0, 1'b0);
        checks++;
        if (ls_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_signed: got %h exp ffffff80", ls_rdata); end
        // store half with a 3-cycle grant delay
        do_txn(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 3, 1, 0, 0, 1'b0);
        checks++;
        if (ls_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL store_keeps_rdata: got %h exp ffffff80", ls_rdata); end
        // misaligned word load
        do_txn(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 32'h0, 0, 0, 0, 0, 1'b0);
        // unsigned half
        do_txn(1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0, 32'h0000_8001, 0, 0, 0, 0, 1'b0);
        checks++;
        if (ls_rdata !== 32'h0000_8001) begin errors++; $display("FAIL lhu: got %h exp 00008001", ls_rdata); end
    endtask

    task automatic test_flush();
        // flush together with the grant, then a normal load
        do_txn(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 32'h0, 2, 0, 1, 2, 1'b0);
        do_txn(1'b0, 2'b10, 1'b0, 32'h0000_4004, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 0, 1'b0);
        // flush while waiting for the response
        do_txn(1'b0, 2'b00, 1'b1, 32'h0000_4001, 32'h0, 32'h1111_2222, 0, 3, 2, 1, 1'b0);
        // flush during the misalign pulse
        do_txn(1'b0, 2'b01, 1'b0, 32'h0000_4003, 32'h0, 32'h0, 0, 0, 3, 0, 1'b0);
        // start together with flush is ignored
        @(negedge clk);
        idle_inputs();
        is_ls = 1'b1; flush = 1'b1; ls_addr = 32'h0000_5000; ls_size = 2'b10;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (dbus_req !== 1'b0 || ls_done !== 1'b0) begin
            errors++; $display("FAIL start_with_flush: got req=%b done=%b exp 0 0", dbus_req, ls_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp2;
        @(negedge clk);
        idle_inputs();
        is_ls = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_unsigned = 1'b0; ls_addr = 32'h0000_6000;
        @(negedge clk);
        idle_inputs();
        dbus_gnt = 1'b1;
        @(negedge clk);
        idle_inputs();
        dbus_rvalid = 1'b1; dbus_rdata = 32'h0BAD_BEEF;
        @(negedge clk);
        idle_inputs();
        is_ls = 1'b1; ls_we = 1'b0; ls_size = 2'b00; ls_unsigned = 1'b1; ls_addr = 32'h0000_7002;
        #1;
        model_rdata = 32'h0BAD_BEEF;
        checks++;
        if (ls_done !== 1'b1 || ls_rdata !== model_rdata) begin
            errors++; $display("FAIL b2b_first: got done=%b rdata=%h exp 1 %h", ls_done, ls_rdata, model_rdata);
        end
        @(negedge clk);
        idle_inputs();
        dbus_gnt = 1'b1;
        #1;
        checks++;
        if (dbus_req !== 1'b1 || dbus_addr !== 32'h0000_7000 || dbus_be !== 4'b0100) begin
            errors++; $display("FAIL b2b_second_req: got req=%b addr=%h be=%b exp 1 00007000 0100", dbus_req, dbus_addr, dbus_be);
        end
        @(negedge clk);
        idle_inputs();
        dbus_rvalid = 1'b1; dbus_rdata = 32'h00A5_0000;
        @(negedge clk);
        idle_inputs();
        #1;
        exp2 = 32'h0000_00A5;
        model_rdata = exp2;
        checks++;
        if (ls_done !== 1'b1 || ls_rdata !== exp2) begin
            errors++; $display("FAIL b2b_second: got done=%b rdata=%h exp 1 %h", ls_done, ls_rdata, exp2);
        end
    endtask

    task automatic test_reset_in_resp();
        @(negedge clk);
        idle_inputs();
        is_ls = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h0000_8000;
        @(negedge clk);
        idle_inputs();
        dbus_gnt = 1'b1;
        @(negedge clk);
        idle_inputs();
        rstb = 1'b0;
        #1;
        model_rdata = 32'h0;
        checks++;
        if (dbus_req !== 1'b0 || ls_done !== 1'b0 || ls_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_resp: got req=%b done=%b rdata=%h exp 0 0 0", dbus_req, ls_done, ls_rdata);
        end
        @(negedge clk);
        rstb = 1'b1;
        dbus_rvalid = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (ls_done !== 1'b0 || ls_rdata !== 32'h0) begin
            errors++; $display("FAIL stale_rvalid: got done=%b rdata=%h exp 0 0", ls_done, ls_rdata);
        end
    endtask

    task automatic test_random();
        logic [1:0]  sz;
        logic [31:0] a;
        int fm;
        int gd;
        int rd;
        for (int t = 0; t < 60; t++) begin
            sz = 2'($urandom);
            a = $urandom;
            if ($urandom_range(0, 9) < 7) a[1:0] = (sz == 2'b00) ? a[1:0] : (sz == 2'b01) ? {a[1], 1'b0} : 2'b00;
            gd = $urandom_range(0, 3);
            rd = $urandom_range(0, 3);
            fm = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
            do_txn(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom, gd, rd, fm,
                   (fm == 1) ? $urandom_range(0, gd) : (fm == 2) ? $urandom_range(0, rd) : 0,
                   1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_back_to_back();
        test_reset_in_resp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
